// File: rtl/pack_scheduler_if.sv
// pack_scheduler_if: request/record bus of the shared packing datapath.
//   req_valid / req_data / req_ready : NUM_REQ byte sources (8 bits each)
//   out_valid / out_ready            : record handshake toward the consumer
//   out_state / out_data / out_id    : packed record and granted index
//   phase                            : per-requester FOO/BAR bits (observability)
// slave  = scheduler side, master = sources/consumer side.
interface pack_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_state;
    logic [31:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic [NUM_REQ-1:0]   phase;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_state, out_data, out_id, phase
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_state, out_data, out_id, phase
    );
endinterface

// File: rtl/pack_scheduler.sv
// pack_scheduler: round-robin arbiter in front of one record-packing stage.
// Each grant builds {~phase[g], ~byte, byte, TOKEN} and toggles phase[g].
// Ports:
//   clock   : rising-edge clock
//   clear_n : synchronous active-low reset
//   bus     : pack_scheduler_if.slave (requests in, record out, phase)
//
// state | meaning
// IDLE  | no record held, out_valid low
// OUT   | record held until out_ready; may be replaced in the same cycle
module pack_scheduler #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TOKEN   = 16'habcd
) (
    input  logic              clock,
    input  logic              clear_n,
    pack_scheduler_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 out_state_q, out_state_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic [NUM_REQ-1:0]   phase_q, phase_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 can_accept;
    logic                 grant_vld;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      cand_idx;
    int                   cand_i;
    logic [7:0]           sel_byte;

    // out_ready only reaches req_ready through can_accept; record outputs are registered.
    assign can_accept = (state_q == IDLE) || bus.out_ready;

    // Scan offsets from farthest to nearest so the first valid index at or after ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_i    = 0;
        cand_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
            cand_idx = ID_W'(cand_i);
            if (bus.req_valid[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_vld = grant_vld & can_accept & clear_n;
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) sel_byte = bus.req_data[i*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        phase_d     = phase_q;
        ptr_d       = ptr_q;
        if (grant_vld) begin
            state_d            = OUT;
            out_state_d        = ~phase_q[grant_idx];
            out_data_d         = {~sel_byte, sel_byte, TOKEN};
            out_id_d           = grant_idx;
            phase_d[grant_idx] = ~phase_q[grant_idx];
            ptr_d              = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (state_q == OUT && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            out_state_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            phase_q     <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_state = out_state_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.phase     = phase_q;
endmodule

// File: tb/tb_pack_scheduler.sv
// Directed bench for pack_scheduler with NUM_REQ=4, TOKEN=16'habcd.
module tb_pack_scheduler;
    logic clock;
    logic clear_n;
    int   tests;
    int   failed;

    pack_scheduler_if #(.NUM_REQ(4)) bus ();

    pack_scheduler #(.NUM_REQ(4), .TOKEN(16'habcd)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rec(input logic [7:0] b);
        return {~b, b, 16'habcd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational req_ready settle after input changes (still before the edge).
    task automatic settle();
        #1;
    endtask

    task automatic chk_rec(input string tag, input logic v, input logic st,
                           input logic [31:0] d, input logic [1:0] id, input logic [3:0] ph);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, ".state"}, {31'd0, bus.out_state}, {31'd0, st});
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".id"},    {30'd0, bus.out_id}, {30'd0, id});
        chk({tag, ".phase"}, {28'd0, bus.phase}, {28'd0, ph});
    endtask

    logic [31:0] bytes4;
    logic [7:0]  b;
    logic [1:0]  exp_g;
    logic [3:0]  exp_ph;

    initial begin
        tests  = 0;
        failed = 0;
        clear_n       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h0;
        bus.out_ready = 1'b1;
        settle();
        chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        tick();
        tick();
        chk_rec("reset", 1'b0, 1'b0, 32'h0, 2'd0, 4'b0000);

        // single requester, two bytes
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0012;
        clear_n       = 1'b1;
        settle();
        chk("s1_ready", {28'd0, bus.req_ready}, 32'h1);
        tick();
        chk_rec("s1", 1'b1, 1'b1, 32'hED12ABCD, 2'd0, 4'b0001);
        bus.req_data = 32'h0000_0000;
        settle();
        chk("s2_ready", {28'd0, bus.req_ready}, 32'h1);
        tick();
        chk_rec("s2", 1'b1, 1'b0, 32'hFF00ABCD, 2'd0, 4'b0000);
        bus.req_valid = 4'b0000;
        settle();
        chk("drain_ready", {28'd0, bus.req_ready}, 32'h0);
        tick();
        chk_rec("drain", 1'b0, 1'b0, 32'hFF00ABCD, 2'd0, 4'b0000);

        // reset to bring ptr back to 0
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;

        // all four valid: grants 0,1,2,3,0 back to back
        bytes4        = 32'h44_33_22_11;
        bus.req_data  = bytes4;
        bus.req_valid = 4'b1111;
        exp_ph        = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            exp_g = 2'(n % 4);
            b     = bytes4[exp_g*8 +: 8];
            settle();
            chk($sformatf("rr%0d_ready", n), {28'd0, bus.req_ready}, 32'h1 << exp_g);
            tick();
            chk_rec($sformatf("rr%0d", n), 1'b1, ~exp_ph[exp_g], rec(b), exp_g,
                    exp_ph ^ (4'b0001 << exp_g));
            exp_ph = exp_ph ^ (4'b0001 << exp_g);
        end

        // backpressure: phase 1110, ptr 1, holding record from requester 0
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            settle();
            chk($sformatf("bp%0d_ready", n), {28'd0, bus.req_ready}, 32'h0);
            tick();
            chk_rec($sformatf("bp%0d", n), 1'b1, 1'b0, 32'hEE11ABCD, 2'd0, 4'b1110);
        end
        bus.out_ready = 1'b1;
        settle();
        chk("bp_release_ready", {28'd0, bus.req_ready}, 32'b0010);
        tick();
        chk_rec("bp_release", 1'b1, 1'b0, rec(8'h22), 2'd1, 4'b1100);

        // req_valid=1010 with ptr=2: grant 3, then 1
        bus.req_valid = 4'b1010;
        settle();
        chk("wrap3_ready", {28'd0, bus.req_ready}, 32'b1000);
        tick();
        chk_rec("wrap3", 1'b1, 1'b0, rec(8'h44), 2'd3, 4'b0100);
        settle();
        chk("wrap1_ready", {28'd0, bus.req_ready}, 32'b0010);
        tick();
        chk_rec("wrap1", 1'b1, 1'b1, rec(8'h22), 2'd1, 4'b0110);

        // steer phase to 0101
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0001;
        tick();
        chk_rec("pre_rst", 1'b1, 1'b1, rec(8'h11), 2'd0, 4'b0101);

        // reset while holding a record
        clear_n       = 1'b0;
        bus.req_valid = 4'b0100;
        settle();
        chk("mid_rst_ready", {28'd0, bus.req_ready}, 32'h0);
        tick();
        chk_rec("mid_rst", 1'b0, 1'b0, 32'h0, 2'd0, 4'b0000);
        clear_n       = 1'b1;
        bus.req_valid = 4'b0101;
        settle();
        chk("post_rst_ptr", {28'd0, bus.req_ready}, 32'b0001);
        tick();
        bus.req_data  = 32'h44_5A_22_11;
        bus.req_valid = 4'b0100;
        settle();
        chk("post_rst2_ready", {28'd0, bus.req_ready}, 32'b0100);
        tick();
        chk_rec("post_rst2", 1'b1, 1'b1, 32'hA55AABCD, 2'd2, 4'b0101);
        bus.req_valid = 4'b0000;
        tick();
        chk("final_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pack_scheduler.md
Name: pack_scheduler

Overview:
- Shares one record-packing datapath among NUM_REQ requesters.
- Each requester offers an 8-bit byte. The block arbitrates round-robin between requesters and builds a packed record {state, data} with data = {~byte, byte, TOKEN}.
- Each requester has its own FOO/BAR phase, which toggles once per accepted grant.
- Sits between the byte sources and the downstream record consumer, with a valid/ready handshake on both sides.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TOKEN, 16'habcd, constant placed in data[15:0] of every record.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  bit i: requester i offers a byte.
- req_data  in  NUM_REQ*8  requester i's byte on [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on bit i when req_valid[i] & req_ready[i].
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- out_state  out  1  record state: 0 = FOO, 1 = BAR.
- out_data  out  32  {~byte, byte, TOKEN}.
- out_id  out  $clog2(NUM_REQ)  index of the granted requester.
- phase  out  NUM_REQ  current per-requester state bits (observability).

Behaviour:
- Reset (clear_n low at a clock edge):
  - out_valid=0, out_state=0, out_data=0, out_id=0.
  - phase=all 0 (FOO); round-robin pointer ptr=0; FSM in IDLE.
  - Any record held in OUT is discarded. req_ready=0 while clear_n is low.
- FSM states:
  - IDLE: out_valid=0.
  - OUT: out_valid=1; out_state, out_data and out_id are held stable until out_ready.
- Grant window (can_accept): state==IDLE, or state==OUT && out_ready.
- Arbitration (combinational, same cycle):
  - When can_accept and any req_valid is set, grant the first valid index searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready is one-hot at the granted index and 0 elsewhere.
  - req_ready is 0 when no request is valid or can_accept is false.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On a grant to index g at edge T:
  - out_state <= ~phase[g].
  - out_data <= {~req_data[g], req_data[g], TOKEN}.
  - out_id <= g.
  - phase[g] <= ~phase[g].
  - ptr <= (g+1) mod NUM_REQ.
  - FSM enters OUT (or stays in OUT).
  - out_valid is high from T+1, so latency is 1 cycle.
- In OUT with out_ready=1 and no grant: return to IDLE; out_valid=0 next cycle; data outputs keep their last values.
- Back-to-back: out_ready=1 together with a grant in the same cycle replaces the record with no bubble. Throughput is 1 record per cycle.
- Backpressure: OUT with out_ready=0 means no grant, no phase or ptr change, and all outputs frozen.
- ptr advances only on a grant; phases of non-granted requesters never change.
- phase toggles even if the record is later discarded by reset. This cannot be observed, because reset clears phase.
- No combinational path from out_ready to out_*. The only combinational path from out_ready is to req_ready.

Test Plan:
- Reset, then req_valid=0001, req_data[0]=8'h12, out_ready=1.
  - Cycle 0: req_ready=0001.
  - Next cycle: out_valid=1, out_data=32'hED12ABCD, out_state=1 (BAR), out_id=0, phase=0001.
- Same requester, second byte 8'h00.
  - Record: out_data=32'hFF00ABCD, out_state=0 (FOO), phase=0000.
- All four req_valid held high, out_ready=1 throughout.
  - Grants in order 0,1,2,3,0, one per cycle.
  - out_id sequence 0,1,2,3,0; first four out_state=1, fifth out_state=0.
- out_ready=0 for 3 cycles while out_valid=1 and req_valid=1111.
  - req_ready=0000; out_data and out_id stable; phase and ptr unchanged.
  - On out_ready=1, the next grant goes to ptr's index in the same cycle.
- req_valid=1010 with ptr=2: grant index 3, then ptr=0, then grant index 1.
- clear_n low for 1 cycle while out_valid=1 and phase=0101.
  - Next cycle: out_valid=0, phase=0000, ptr=0, req_ready=0 during the reset cycle.
  - Subsequent request from index 2 yields out_state=1.
